// File: rtl/multicycle_muldiv.sv
// Iterative multiply/divide unit producing HI/LO results for the multi-cycle CPU.
// The control unit launches an operation with a start pulse and stalls while busy.
// Multiply is shift-add and divide is restoring, both on operand magnitudes.
// Signs are applied in a final FIXUP cycle, which is also the only cycle that writes hi/lo.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        launch request, honoured only in IDLE or DONE
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         operands, latched when a start is accepted
//   flush        synchronous abort back to IDLE, leaving hi/lo untouched
//   busy         high while in CALC or FIXUP
//   done         one-cycle pulse when hi/lo carry a new result
//   div_by_zero  set with done for a divide by zero, cleared on the next accepted start
//   hi, lo       MUL: upper/lower product halves; DIV: remainder/quotient
module multicycle_muldiv #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               div_q;     // operation is a divide
  logic               dbz_q;     // divide by zero: skip CALC, raw dividend kept in acc_q
  logic               neg_q;     // negate product / quotient in FIXUP
  logic               rneg_q;    // negate remainder in FIXUP
  logic [WIDTH-1:0]   opnd_q;    // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;     // MUL: {partial product, multiplier}; DIV: low half = quotient/dividend
  logic [WIDTH-1:0]   rem_q;     // divide partial remainder

  // Operand decode for an accepted start
  logic             accept;
  logic             a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    a_neg    = ~op[0] & a[WIDTH-1];
    b_neg    = ~op[0] & b[WIDTH-1];
    mag_a    = a_neg ? -a : a;
    mag_b    = b_neg ? -b : b;
    div_zero = op[1] & (b == '0);
  end

  // Next-state logic; flush overrides everything, including a simultaneous start
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start) begin
            accept  = 1'b1;
            state_d = div_zero ? S_FIXUP : S_CALC;
          end
        end
        S_CALC:  if (cnt_q == '0) state_d = S_FIXUP;
        S_FIXUP: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // One CALC cycle: BITS_PER_CYCLE single-bit shift-add or restoring-divide steps
  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH:0]     rem_sh, diff, sum;

  always_comb begin
    step_acc = acc_q;
    step_rem = rem_q;
    rem_sh   = '0;
    diff     = '0;
    sum      = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (div_q) begin
        rem_sh   = {step_rem, step_acc[WIDTH-1]};
        diff     = rem_sh - {1'b0, opnd_q};
        // diff[WIDTH] set means the trial subtraction borrowed: restore
        step_acc = {step_acc[2*WIDTH-1:WIDTH], step_acc[WIDTH-2:0], ~diff[WIDTH]};
        step_rem = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      end else begin
        sum      = {1'b0, step_acc[2*WIDTH-1:WIDTH]} + (step_acc[0] ? {1'b0, opnd_q} : '0);
        step_acc = {sum, step_acc[WIDTH-1:1]};
      end
    end
  end

  // Sign application for FIXUP
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    prod_fix = neg_q  ? -acc_q : acc_q;
    quot_fix = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rneg_q ? -rem_q : rem_q;
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= 1'b0;
      dbz_q       <= 1'b0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      opnd_q      <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == S_CALC) || (state_d == S_FIXUP);
      done    <= (state_d == S_DONE);
      if (accept) begin
        cnt_q       <= CNT_W'(N - 1);
        div_q       <= op[1];
        dbz_q       <= div_zero;
        neg_q       <= a_neg ^ b_neg;
        rneg_q      <= a_neg;
        rem_q       <= '0;
        div_by_zero <= 1'b0;
        if (div_zero) begin
          opnd_q <= '0;
          acc_q  <= {{WIDTH{1'b0}}, a};
        end else if (op[1]) begin
          opnd_q <= mag_b;
          acc_q  <= {{WIDTH{1'b0}}, mag_a};
        end else begin
          opnd_q <= mag_a;
          acc_q  <= {{WIDTH{1'b0}}, mag_b};
        end
      end else if ((state_q == S_CALC) && !flush) begin
        acc_q <= step_acc;
        rem_q <= step_rem;
        cnt_q <= cnt_q - CNT_W'(1);
      end else if ((state_q == S_FIXUP) && !flush) begin
        div_by_zero <= dbz_q;
        if (dbz_q) begin
          hi <= acc_q[WIDTH-1:0];
          lo <= '1;
        end else if (div_q) begin
          hi <= rem_fix;
          lo <= quot_fix;
        end else begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_multicycle_muldiv.sv
// Bench for multicycle_muldiv: directed cases with literal results, then random traffic
// checked every cycle against a cycle-count / arithmetic reference model.
module tb_multicycle_muldiv;

  localparam int unsigned W   = 32;
  localparam int unsigned BPC = 1;
  localparam int unsigned N   = W / BPC;

  logic         clk, rst_n, start, flush;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  multicycle_muldiv #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Arithmetic reference: {dbz, hi, lo}
  function automatic logic [64:0] ref_res(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    if (o[1] && y == '0) return {1'b1, x, 32'hFFFF_FFFF};
    case (o)
      2'b00: p = 64'(sx * sy);
      2'b01: p = {32'b0, x} * {32'b0, y};
      2'b10: begin q = sx / sy; r = sx % sy; p = {32'(r), 32'(q)}; end
      default: p = {x % y, x / y};
    endcase
    return {1'b0, p};
  endfunction

  // Reference model: counts cycles to completion, results from plain arithmetic
  int          m_left;
  logic        m_done, m_dbz, p_dbz;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_hi <= '0; m_lo <= '0; p_hi <= '0; p_lo <= '0; p_dbz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (flush) begin
        m_left <= 0;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1; m_hi <= p_hi; m_lo <= p_lo; m_dbz <= p_dbz;
        end
      end else if (start) begin
        {p_dbz, p_hi, p_lo} <= ref_res(op, a, b);
        m_dbz  <= 1'b0;
        m_left <= (op[1] && b == '0) ? 1 : int'(N) + 1;
      end
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("busy",        64'(busy),        64'(m_left != 0));
      chk("done",        64'(done),        64'(m_done));
      chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
      chk("hi",          64'(hi),          64'(m_hi));
      chk("lo",          64'(lo),          64'(m_lo));
    end
  end

  // Launch one op, wait (bounded) for done, check latency and literal results
  task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] e_hi,
                        input logic [W-1:0] e_lo, input logic e_dbz, input int e_lat);
    int cnt;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    for (cnt = 1; cnt < int'(N) + 20; cnt++) begin
      if (done) break;
      @(negedge clk);
    end
    chk({nm, "_latency"}, 64'(cnt), 64'(e_lat));
    chk({nm, "_hi"},  64'(hi), 64'(e_hi));
    chk({nm, "_lo"},  64'(lo), 64'(e_lo));
    chk({nm, "_dbz"}, 64'(div_by_zero), 64'(e_dbz));
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      4: return 32'(0) - 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    bit saw_done;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_dbz",  64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, N + 2);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, N + 2);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, N + 2);
    run_op("div_min",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, N + 2);
    run_op("divu_zero", 2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 2);
    run_op("divu_7",    2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, N + 2);

    // Flush mid-run, with an ignored start pulse at edge 5
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd99; b = 32'd99;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi",   64'(hi), 64'h2);
    chk("flush_lo",   64'(lo), 64'hE);
    saw_done = 1'b0;
    repeat (N + 5) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("flush_no_done", 64'(saw_done), 64'd0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("multu_3x4", 2'b01, 32'd3, 32'd4, 32'h0, 32'h0000_000C, 1'b0, N + 2);

    // Random traffic: frequent starts (including while busy), occasional flush
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = rnd_opnd();
      b     = rnd_opnd();
      flush = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    repeat (N + 5) @(negedge clk);
    chk_en = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
